// File: rtl/ex_wb_arb_pkg.sv
// Shared widths for the execute-to-ROB writeback arbiter.
// Holds the PC width and the completion-record packing width.
package ex_wb_arb_pkg;

  localparam int PC_W = 32;

  // Record layout, MSB first: rob_id, rob_bank, fls, exc, opera, operb, fls_tgt.
  function automatic int wb_pw(input int rob_depth, input int commit_width,
                               input int aw, input int dw);
    return rob_depth + commit_width + 2 + aw + dw + PC_W;
  endfunction

endpackage

// File: rtl/ex_wb_rr_pick.sv
// Round-robin multi-grant picker: grants up to f_cnt requesting lanes,
// scanning from rr_ptr, and lists the winners in scan order.
module ex_wb_rr_pick #(
  parameter int P_IW = 2,
  parameter int P_NP = 1,
  localparam int IW = 1 << P_IW,
  localparam int NP = 1 << P_NP
) (
  input  logic [IW-1:0]            req,
  input  logic [P_IW-1:0]          rr_ptr,
  input  logic [P_NP:0]            f_cnt,
  output logic [IW-1:0]            grant,
  output logic [NP-1:0][P_IW-1:0]  win_lane,
  output logic [P_NP:0]            win_cnt,
  output logic [P_IW-1:0]          last_lane
);

  // NOTE: every output gets a default before the loop so no latch is inferred,
  // and blocking assignments are used because win_cnt is a running count
  // that later iterations must see updated.
  always_comb begin
    logic [P_IW-1:0] lane;
    grant     = '0;
    win_lane  = '0;
    win_cnt   = '0;
    last_lane = rr_ptr;
    for (int j = 0; j < IW; j++) begin
      // IW is a power of two, so the natural wrap of lane gives mod IW.
      lane = rr_ptr + P_IW'(j);
      if (req[lane] && (win_cnt < f_cnt)) begin
        grant[lane]                  = 1'b1;
        win_lane[win_cnt[P_NP-1:0]]  = lane;
        win_cnt                      = win_cnt + (P_NP+1)'(1);
        last_lane                    = lane;
      end
    end
  end

endmodule

// File: rtl/ex_wb_arb.sv
// Arbitrates IW execute-lane completion records onto NP registered ROB
// writeback ports, round-robin, with per-lane ready backpressure.
module ex_wb_arb
  import ex_wb_arb_pkg::*;
#(
  parameter int CONFIG_AW             = 8,
  parameter int CONFIG_DW             = 8,
  parameter int CONFIG_P_ISSUE_WIDTH  = 2,
  parameter int CONFIG_P_WB_PORTS     = 1,
  parameter int CONFIG_P_ROB_DEPTH    = 4,
  parameter int CONFIG_P_COMMIT_WIDTH = 1,
  localparam int AW = CONFIG_AW,
  localparam int DW = CONFIG_DW,
  localparam int PI = CONFIG_P_ISSUE_WIDTH,
  localparam int PP = CONFIG_P_WB_PORTS,
  localparam int RD = CONFIG_P_ROB_DEPTH,
  localparam int CW = CONFIG_P_COMMIT_WIDTH,
  localparam int IW = 1 << PI,
  localparam int NP = 1 << PP
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [IW-1:0]      ex_wb_valid,
  output logic [IW-1:0]      ex_wb_ready,
  input  logic [IW*RD-1:0]   ex_wb_rob_id,
  input  logic [IW*CW-1:0]   ex_wb_rob_bank,
  input  logic [IW-1:0]      ex_wb_fls,
  input  logic [IW-1:0]      ex_wb_exc,
  input  logic [IW*AW-1:0]   ex_wb_opera,
  input  logic [IW*DW-1:0]   ex_wb_operb,
  input  logic [IW*PC_W-1:0] ex_wb_fls_tgt,
  output logic [NP-1:0]      rob_wb_valid,
  input  logic [NP-1:0]      rob_wb_ready,
  output logic [NP*RD-1:0]   rob_wb_rob_id,
  output logic [NP*CW-1:0]   rob_wb_rob_bank,
  output logic [NP-1:0]      rob_wb_fls,
  output logic [NP-1:0]      rob_wb_exc,
  output logic [NP*AW-1:0]   rob_wb_opera,
  output logic [NP*DW-1:0]   rob_wb_operb,
  output logic [NP*PC_W-1:0] rob_wb_fls_tgt,
  output logic [NP*PI-1:0]   rob_wb_lane
);

  localparam int PW = wb_pw(RD, CW, AW, DW);

  logic [PW-1:0]          lane_pl [IW];
  logic [IW-1:0]          req;
  logic [IW-1:0]          grant;
  logic [NP-1:0]          free;
  logic [PP:0]            f_cnt;
  logic [NP-1:0][PI-1:0]  win_lane;
  logic [PP:0]            win_cnt;
  logic [PI-1:0]          last_lane;
  logic [PI-1:0]          rr_ptr;
  logic [NP-1:0]          load;
  logic [NP-1:0][PI-1:0]  load_lane;

  for (genvar i = 0; i < IW; i++) begin : g_lane
    assign lane_pl[i] = {ex_wb_rob_id[i*RD +: RD], ex_wb_rob_bank[i*CW +: CW],
                         ex_wb_fls[i], ex_wb_exc[i], ex_wb_opera[i*AW +: AW],
                         ex_wb_operb[i*DW +: DW], ex_wb_fls_tgt[i*PC_W +: PC_W]};
  end

  // Reset and flush both suppress every grant, which keeps ex_wb_ready low.
  assign req         = (rst && !flush) ? ex_wb_valid : '0;
  assign free        = ~rob_wb_valid | rob_wb_ready;
  assign f_cnt       = (PP+1)'($countones(free));
  assign ex_wb_ready = grant;

  ex_wb_rr_pick #(
    .P_IW (PI),
    .P_NP (PP)
  ) u_pick (
    .req       (req),
    .rr_ptr    (rr_ptr),
    .f_cnt     (f_cnt),
    .grant     (grant),
    .win_lane  (win_lane),
    .win_cnt   (win_cnt),
    .last_lane (last_lane)
  );

  // The k-th winner in scan order lands on the k-th free port by index.
  always_comb begin
    logic [PP:0] rank;
    rank      = '0;
    load      = '0;
    load_lane = '0;
    for (int p = 0; p < NP; p++) begin
      if (free[p]) begin
        if (rank < win_cnt) begin
          load[p]      = 1'b1;
          load_lane[p] = win_lane[rank[PP-1:0]];
        end
        rank = rank + (PP+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr <= '0;
    end else if (|grant) begin
      rr_ptr <= last_lane + PI'(1);
    end
  end

  for (genvar p = 0; p < NP; p++) begin : g_port
    logic          valid_q;
    logic [PW-1:0] pl_q;
    logic [PI-1:0] lane_q;

    always_ff @(posedge clk) begin
      if (!rst) begin
        valid_q <= 1'b0;
      end else if (flush) begin
        valid_q <= 1'b0;
      end else if (load[p]) begin
        valid_q <= 1'b1;
      end else if (rob_wb_ready[p]) begin
        valid_q <= 1'b0;
      end
    end

    // NOTE: payload registers carry no reset; they are only meaningful while
    // valid_q is set, and they load only on a real transfer.
    always_ff @(posedge clk) begin
      if (load[p]) begin
        pl_q   <= lane_pl[load_lane[p]];
        lane_q <= load_lane[p];
      end
    end

    assign rob_wb_valid[p]           = valid_q;
    assign rob_wb_lane[p*PI +: PI]   = lane_q;
    assign {rob_wb_rob_id[p*RD +: RD], rob_wb_rob_bank[p*CW +: CW],
            rob_wb_fls[p], rob_wb_exc[p], rob_wb_opera[p*AW +: AW],
            rob_wb_operb[p*DW +: DW], rob_wb_fls_tgt[p*PC_W +: PC_W]} = pl_q;
  end

endmodule

// File: tb/tb_ex_wb_arb.sv
// Directed bench for ex_wb_arb with IW=4 lanes and NP=2 ports.
// Lane i presents rob_id 9+i, opera A0+i, fls_tgt 0x1000_0000+16*i.
module tb_ex_wb_arb;
  import ex_wb_arb_pkg::*;

  localparam int AW = 8, DW = 8, PI = 2, PP = 1, RD = 4, CW = 1;
  localparam int IW = 4, NP = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               flush;
  logic [IW-1:0]      ex_wb_valid;
  logic [IW-1:0]      ex_wb_ready;
  logic [IW*RD-1:0]   ex_wb_rob_id;
  logic [IW*CW-1:0]   ex_wb_rob_bank;
  logic [IW-1:0]      ex_wb_fls;
  logic [IW-1:0]      ex_wb_exc;
  logic [IW*AW-1:0]   ex_wb_opera;
  logic [IW*DW-1:0]   ex_wb_operb;
  logic [IW*PC_W-1:0] ex_wb_fls_tgt;
  logic [NP-1:0]      rob_wb_valid;
  logic [NP-1:0]      rob_wb_ready;
  logic [NP*RD-1:0]   rob_wb_rob_id;
  logic [NP*CW-1:0]   rob_wb_rob_bank;
  logic [NP-1:0]      rob_wb_fls;
  logic [NP-1:0]      rob_wb_exc;
  logic [NP*AW-1:0]   rob_wb_opera;
  logic [NP*DW-1:0]   rob_wb_operb;
  logic [NP*PC_W-1:0] rob_wb_fls_tgt;
  logic [NP*PI-1:0]   rob_wb_lane;

  int n_vec = 0;
  int n_err = 0;

  ex_wb_arb #(
    .CONFIG_AW             (AW),
    .CONFIG_DW             (DW),
    .CONFIG_P_ISSUE_WIDTH  (PI),
    .CONFIG_P_WB_PORTS     (PP),
    .CONFIG_P_ROB_DEPTH    (RD),
    .CONFIG_P_COMMIT_WIDTH (CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .ex_wb_valid     (ex_wb_valid),
    .ex_wb_ready     (ex_wb_ready),
    .ex_wb_rob_id    (ex_wb_rob_id),
    .ex_wb_rob_bank  (ex_wb_rob_bank),
    .ex_wb_fls       (ex_wb_fls),
    .ex_wb_exc       (ex_wb_exc),
    .ex_wb_opera     (ex_wb_opera),
    .ex_wb_operb     (ex_wb_operb),
    .ex_wb_fls_tgt   (ex_wb_fls_tgt),
    .rob_wb_valid    (rob_wb_valid),
    .rob_wb_ready    (rob_wb_ready),
    .rob_wb_rob_id   (rob_wb_rob_id),
    .rob_wb_rob_bank (rob_wb_rob_bank),
    .rob_wb_fls      (rob_wb_fls),
    .rob_wb_exc      (rob_wb_exc),
    .rob_wb_opera    (rob_wb_opera),
    .rob_wb_operb    (rob_wb_operb),
    .rob_wb_fls_tgt  (rob_wb_fls_tgt),
    .rob_wb_lane     (rob_wb_lane)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst          = 1'b0;
    flush        = 1'b0;
    ex_wb_valid  = 4'b1111;
    rob_wb_ready = 2'b11;
    for (int i = 0; i < IW; i++) begin
      ex_wb_rob_id[i*RD +: RD]       = RD'(9 + i);
      ex_wb_rob_bank[i*CW +: CW]     = CW'(i % 2);
      ex_wb_fls[i]                   = (i == 1);
      ex_wb_exc[i]                   = (i == 2);
      ex_wb_opera[i*AW +: AW]        = AW'(8'hA0 + i);
      ex_wb_operb[i*DW +: DW]        = DW'(8'h50 + i);
      ex_wb_fls_tgt[i*PC_W +: PC_W]  = 32'h1000_0000 + 32'(16 * i);
    end

    // Reset held with every lane requesting.
    repeat (3) begin
      tick();
      check("rst_valid", 64'(rob_wb_valid), 64'b00);
      check("rst_ready", 64'(ex_wb_ready), 64'b0000);
    end

    // Release: lanes 0,1 first, then alternating halves.
    rst = 1'b1;
    #1;
    check("rel_ready", 64'(ex_wb_ready), 64'b0011);
    tick();
    check("rel_valid", 64'(rob_wb_valid), 64'b11);
    check("rel_lane", 64'(rob_wb_lane), 64'b0100);
    check("rel_rob_id", 64'(rob_wb_rob_id), 64'hA9);
    check("rr1_ready", 64'(ex_wb_ready), 64'b1100);
    tick();
    check("rr1_lane", 64'(rob_wb_lane), 64'b1110);
    check("rr1_rob_id", 64'(rob_wb_rob_id), 64'hCB);
    check("rr1_exc", 64'(rob_wb_exc), 64'b01);
    check("rr2_ready", 64'(ex_wb_ready), 64'b0011);
    tick();
    check("rr2_lane", 64'(rob_wb_lane), 64'b0100);
    check("rr2_fls", 64'(rob_wb_fls), 64'b10);

    // Port 0 stalls holding lane 0; lane 2 must land on port 1.
    ex_wb_valid  = 4'b0100;
    rob_wb_ready = 2'b10;
    #1;
    check("stall_ready", 64'(ex_wb_ready), 64'b0100);
    tick();
    check("stall_valid", 64'(rob_wb_valid), 64'b11);
    check("stall_lane", 64'(rob_wb_lane), 64'b1000);
    check("stall_rob_id", 64'(rob_wb_rob_id), 64'hB9);
    check("stall_opera", 64'(rob_wb_opera), 64'hA2A0);

    // Both ports full and stalled: no grants, payload stable.
    ex_wb_valid  = 4'b1111;
    rob_wb_ready = 2'b00;
    repeat (3) begin
      #1;
      check("full_ready", 64'(ex_wb_ready), 64'b0000);
      tick();
      check("full_valid", 64'(rob_wb_valid), 64'b11);
      check("full_lane", 64'(rob_wb_lane), 64'b1000);
      check("full_opera", 64'(rob_wb_opera), 64'hA2A0);
      check("full_tgt", 64'(rob_wb_fls_tgt), 64'h10000020_10000000);
    end

    // Resume from lane 3 (pointer was 3 after the lane-2 grant).
    rob_wb_ready = 2'b11;
    #1;
    check("resume_ready", 64'(ex_wb_ready), 64'b1001);
    tick();
    check("resume_valid", 64'(rob_wb_valid), 64'b11);
    check("resume_lane", 64'(rob_wb_lane), 64'b0011);
    check("resume_rob_id", 64'(rob_wb_rob_id), 64'h9C);

    // Flush with both slots full and lanes 1,3 requesting.
    flush        = 1'b1;
    ex_wb_valid  = 4'b1010;
    rob_wb_ready = 2'b00;
    #1;
    check("flush_ready", 64'(ex_wb_ready), 64'b0000);
    tick();
    check("flush_valid", 64'(rob_wb_valid), 64'b00);
    flush = 1'b0;
    #1;
    check("postflush_ready", 64'(ex_wb_ready), 64'b1010);
    tick();
    check("postflush_lane", 64'(rob_wb_lane), 64'b1101);
    check("postflush_rob_id", 64'(rob_wb_rob_id), 64'hCA);
    check("postflush_fls", 64'(rob_wb_fls), 64'b01);

    // Pointer now 0: lone lane 3 goes to port 0 and the pointer wraps to 0.
    ex_wb_valid  = 4'b1000;
    rob_wb_ready = 2'b11;
    #1;
    check("single_ready", 64'(ex_wb_ready), 64'b1000);
    tick();
    check("single_valid", 64'(rob_wb_valid), 64'b01);
    check("single_lane", 64'(rob_wb_lane[1:0]), 64'd3);
    check("single_rob_id", 64'(rob_wb_rob_id[3:0]), 64'd12);
    check("single_tgt", 64'(rob_wb_fls_tgt[31:0]), 64'h10000030);
    ex_wb_valid = 4'b1001;
    #1;
    check("wrap_ready", 64'(ex_wb_ready), 64'b1001);
    tick();
    check("wrap_lane", 64'(rob_wb_lane), 64'b1100);
    check("wrap_valid", 64'(rob_wb_valid), 64'b11);

    // Reset and flush together: reset dominates, pointer returns to 0.
    rst         = 1'b0;
    flush       = 1'b1;
    ex_wb_valid = 4'b1111;
    #1;
    check("rstfl_ready", 64'(ex_wb_ready), 64'b0000);
    tick();
    check("rstfl_valid", 64'(rob_wb_valid), 64'b00);
    rst         = 1'b1;
    flush       = 1'b0;
    ex_wb_valid = 4'b0110;
    #1;
    check("rstfl2_ready", 64'(ex_wb_ready), 64'b0110);
    tick();
    check("rstfl2_lane", 64'(rob_wb_lane), 64'b1001);
    check("rstfl2_valid", 64'(rob_wb_valid), 64'b11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
